// File: rtl/cpu_pkg.sv
// Shared types and widths for the 16-bit CPU front end.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: instruction memory request/response, decode handoff and redirect.
interface pc_fetch_unit_if;
  import cpu_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic               imem_req;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_o;
  logic [PC_W-1:0]    instr_pc_o;
  logic               instr_valid;
  logic               instr_ready;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;

  modport master (
    output imem_addr, imem_req, instr_o, instr_pc_o, instr_valid,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_req, instr_o, instr_pc_o, instr_valid,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/pc_fetch_unit_pc_incr.sv
// Sequential-PC adder; the carry-out exists only so wrap-around is explicit.
module pc_incr
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] a,
  input  logic [PC_W-1:0] b,
  input  logic            cin,
  output logic [PC_W-1:0] sum,
  output logic            cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{PC_W{1'b0}}, cin};

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch with redirect priority.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_fetch_unit_if.master  fetch_bus
);

  fetch_state_t       r_state, w_state_next;
  logic [PC_W-1:0]    r_pc, w_pc_next;
  logic               r_drop, w_drop_next;
  logic [INSTR_W-1:0] r_instr, w_instr_next;
  logic [PC_W-1:0]    r_instr_pc, w_instr_pc_next;
  logic               r_valid, w_valid_next;
  logic [PC_W-1:0]    w_pc_plus1;
  logic               w_cout_unused;

  pc_incr u_pc_incr (
    .a    (r_pc),
    .b    (16'h0001),
    .cin  (1'b0),
    .sum  (w_pc_plus1),
    .cout (w_cout_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_drop     <= w_drop_next;
      r_instr    <= w_instr_next;
      r_instr_pc <= w_instr_pc_next;
      r_valid    <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_drop_next     = r_drop;
    w_instr_next    = r_instr;
    w_instr_pc_next = r_instr_pc;
    w_valid_next    = r_valid;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_REQ;
        if (fetch_bus.redirect_valid) w_pc_next = fetch_bus.redirect_pc;
      end
      ST_REQ: begin
        if (fetch_bus.imem_gnt) begin
          w_state_next = ST_WAIT;
          // The granted address is already stale; its response must be discarded.
          if (fetch_bus.redirect_valid) begin
            w_drop_next = 1'b1;
            w_pc_next   = fetch_bus.redirect_pc;
          end
        end else if (fetch_bus.redirect_valid) begin
          w_pc_next = fetch_bus.redirect_pc;
        end
      end
      ST_WAIT: begin
        if (fetch_bus.redirect_valid) begin
          w_pc_next = fetch_bus.redirect_pc;
          if (fetch_bus.imem_rvalid) begin
            w_drop_next  = 1'b0;
            w_state_next = ST_REQ;
          end else begin
            w_drop_next = 1'b1;
          end
        end else if (fetch_bus.imem_rvalid) begin
          if (r_drop) begin
            w_drop_next  = 1'b0;
            w_state_next = ST_REQ;
          end else begin
            w_instr_next    = fetch_bus.imem_rdata;
            w_instr_pc_next = r_pc;
            w_pc_next       = w_pc_plus1;
            w_valid_next    = 1'b1;
            w_state_next    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (fetch_bus.redirect_valid) begin
          w_valid_next = 1'b0;
          w_pc_next    = fetch_bus.redirect_pc;
          w_state_next = ST_REQ;
        end else if (fetch_bus.instr_ready) begin
          w_valid_next = 1'b0;
          w_state_next = ST_REQ;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign fetch_bus.imem_addr   = r_pc;
  assign fetch_bus.imem_req    = (r_state == ST_REQ);
  assign fetch_bus.instr_o     = r_instr;
  assign fetch_bus.instr_pc_o  = r_instr_pc;
  assign fetch_bus.instr_valid = r_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized and directed check of pc_fetch_unit against a PC-stream model.
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  localparam logic [15:0] RESET_PC = 16'h0010;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_fetch_unit_if bus();

  pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory contents as a function of address, so every word identifies its source.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        force_gnt = 1'b0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_addr = '0;
  logic        busy = 1'b0;
  logic [15:0] gnt_q[$];

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
  end

  always @(negedge clk) begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 16'($urandom);
    busy = pend;
    if (pend) begin
      if (pend_cnt == 1) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = memf(pend_addr);
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (bus.imem_req && !busy && (force_gnt || $urandom_range(99, 0) < gnt_pct)) begin
      bus.imem_gnt = 1'b1;
      pend      = 1'b1;
      pend_addr = bus.imem_addr;
      pend_cnt  = $urandom_range(lat_max, lat_min);
      gnt_q.push_back(bus.imem_addr);
    end
  end

  // Model: the decode stream is RESET_PC, then +1 per acceptance, restarting at each redirect target.
  logic [15:0] exp_pc = RESET_PC;
  logic        prev_hold = 1'b0;
  logic        accept;
  int          cyc = 0;
  int          acc_total = 0;
  logic [15:0] acc_pc[$];
  logic [15:0] acc_w[$];
  int          acc_cyc[$];

  always @(negedge clk) begin
    #2;
    cyc++;
    if (!rst_n) begin
      exp_pc    = RESET_PC;
      prev_hold = 1'b0;
      chk("rst_addr", 32'(bus.imem_addr), 32'(RESET_PC));
      chk("rst_req", 32'(bus.imem_req), 0);
      chk("rst_valid", 32'(bus.instr_valid), 0);
      chk("rst_instr", 32'(bus.instr_o), 0);
      chk("rst_instr_pc", 32'(bus.instr_pc_o), 0);
    end else begin
      chk("req_while_outstanding", 32'(bus.imem_req && busy), 0);
      chk("req_during_valid", 32'(bus.imem_req && bus.instr_valid), 0);
      if (bus.imem_req) chk("fetch_addr", 32'(bus.imem_addr), 32'(exp_pc));
      if (prev_hold) chk("valid_held", 32'(bus.instr_valid), 1);
      if (bus.instr_valid) begin
        chk("instr_pc", 32'(bus.instr_pc_o), 32'(exp_pc));
        chk("instr_word", 32'(bus.instr_o), 32'(memf(exp_pc)));
      end
      accept    = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
      prev_hold = bus.instr_valid && !accept && !bus.redirect_valid;
      if (bus.redirect_valid) begin
        exp_pc = bus.redirect_pc;
      end else if (accept) begin
        acc_pc.push_back(bus.instr_pc_o);
        acc_w.push_back(bus.instr_o);
        acc_cyc.push_back(cyc);
        acc_total++;
        exp_pc = exp_pc + 16'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (acc_pc.size() < n && k < budget) begin
      step();
      k++;
    end
    if (acc_pc.size() < n) chk("acc_timeout", 32'(acc_pc.size()), 32'(n));
  endtask

  // First cycle of WAIT for a request whose latency is 3.
  task automatic wait_in_wait(input int budget);
    int k = 0;
    while (!(pend && !bus.imem_req && pend_cnt == 3) && k < budget) begin
      step();
      k++;
    end
    chk("wait_state_reached", 32'(pend && !bus.imem_req), 1);
  endtask

  task automatic pulse_redirect(input logic [15:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] addr_next;
    int k;
    rst_n              = 1'b0;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) step();
    chk("reset_addr_lit", 32'(bus.imem_addr), 32'h0010);
    chk("reset_req_lit", 32'(bus.imem_req), 0);

    // Zero-wait memory, decode always ready.
    rst_n = 1'b1;
    acc_pc.delete(); acc_w.delete(); acc_cyc.delete();
    chk("req_low_idle", 32'(bus.imem_req), 0);
    step();
    chk("req_rise", 32'(bus.imem_req), 1);
    chk("first_addr", 32'(bus.imem_addr), 32'h0010);
    wait_acc(3, 40);
    if (acc_pc.size() >= 3) begin
      chk("seq_pc0", 32'(acc_pc[0]), 32'h0010);
      chk("seq_pc1", 32'(acc_pc[1]), 32'h0011);
      chk("seq_pc2", 32'(acc_pc[2]), 32'h0012);
      chk("seq_word0", 32'(acc_w[0]), 32'h4A3C);
      chk("rate_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 3);
      chk("rate_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 3);
    end

    // Decode backpressure in HOLD.
    bus.instr_ready = 1'b0;
    k = 0;
    while (!bus.instr_valid && k < 20) begin step(); k++; end
    chk("bp_valid_seen", 32'(bus.instr_valid), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      addr_next = exp_pc + 16'd1;
      chk("bp_valid", 32'(bus.instr_valid), 1);
      chk("bp_req", 32'(bus.imem_req), 0);
      chk("bp_word", 32'(bus.instr_o), 32'(memf(exp_pc)));
      chk("bp_addr", 32'(bus.imem_addr), 32'(addr_next));
    end
    bus.instr_ready = 1'b1;

    // Redirect in WAIT, stale response two cycles later.
    lat_min = 3; lat_max = 3;
    wait_in_wait(30);
    gnt_q.delete(); acc_pc.delete(); acc_w.delete(); acc_cyc.delete();
    pulse_redirect(16'h0200);
    lat_min = 1; lat_max = 1;
    wait_acc(1, 40);
    if (acc_pc.size() >= 1) chk("wait_redir_pc", 32'(acc_pc[0]), 32'h0200);
    if (gnt_q.size() >= 1) chk("wait_redir_fetch", 32'(gnt_q[0]), 32'h0200);

    // Redirect coinciding with the grant for 0x0005.
    gnt_pct = 0;
    pulse_redirect(16'h0005);
    k = 0;
    while (!(bus.imem_req && bus.imem_addr == 16'h0005) && k < 30) begin step(); k++; end
    chk("req_at_0005", 32'(bus.imem_req && bus.imem_addr == 16'h0005), 1);
    gnt_q.delete(); acc_pc.delete(); acc_w.delete(); acc_cyc.delete();
    force_gnt = 1'b1;
    pulse_redirect(16'h0040);
    force_gnt = 1'b0;
    gnt_pct   = 100;
    wait_acc(1, 40);
    if (acc_pc.size() >= 1) chk("gnt_redir_pc", 32'(acc_pc[0]), 32'h0040);
    if (gnt_q.size() >= 2) begin
      chk("gnt_redir_fetch0", 32'(gnt_q[0]), 32'h0005);
      chk("gnt_redir_fetch1", 32'(gnt_q[1]), 32'h0040);
    end

    // Wrap-around.
    acc_pc.delete(); acc_w.delete(); acc_cyc.delete();
    pulse_redirect(16'hFFFF);
    wait_acc(2, 40);
    if (acc_pc.size() >= 2) begin
      chk("wrap_pc0", 32'(acc_pc[0]), 32'hFFFF);
      chk("wrap_pc1", 32'(acc_pc[1]), 32'h0000);
      chk("wrap_word0", 32'(acc_w[0]), 32'hA5C3);
      chk("wrap_word1", 32'(acc_w[1]), 32'h5A3C);
    end

    // Randomized traffic.
    gnt_pct = 60; lat_min = 1; lat_max = 3;
    k = acc_total;
    for (int i = 0; i < 1500; i++) begin
      bus.instr_ready    = ($urandom_range(9, 0) < 7);
      bus.redirect_valid = ($urandom_range(39, 0) == 0);
      bus.redirect_pc    = ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom);
      step();
    end
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    chk("random_liveness", 32'((acc_total - k) >= 50), 1);

    // Reset during WAIT, response arrives after release.
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    repeat (10) step();
    wait_in_wait(30);
    rst_n = 1'b0;
    acc_pc.delete(); acc_w.delete(); acc_cyc.delete();
    step();
    step();
    rst_n = 1'b1;
    chk("rst_mid_req", 32'(bus.imem_req), 0);
    step();
    chk("rst_mid_no_valid", 32'(bus.instr_valid), 0);
    chk("rst_mid_req_rise", 32'(bus.imem_req), 1);
    chk("rst_mid_addr", 32'(bus.imem_addr), 32'h0010);
    lat_min = 1; lat_max = 1;
    wait_acc(1, 40);
    if (acc_pc.size() >= 1) chk("rst_mid_restart_pc", 32'(acc_pc[0]), 32'h0010);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the 16-bit CPU. It holds the PC register and computes the sequential next PC through a 16-bit incrementer. It issues one request at a time to instruction memory and hands each fetched word to decode over a valid/ready handshake. Branch and jump targets from execute arrive on a redirect port and take priority over sequential fetch.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `imem_addr`  out  16: fetch address; equals `pc_q`.
- `imem_req`  out  1: fetch request.
- `imem_gnt`  in  1: request accepted this cycle when `imem_req` is also high.
- `imem_rvalid`  in  1: read data valid; earliest one cycle after grant.
- `imem_rdata`  in  16: fetched instruction word.
- `instr_o`  out  16: instruction presented to decode.
- `instr_pc_o`  out  16: address `instr_o` was fetched from.
- `instr_valid`  out  1: `instr_o`/`instr_pc_o` valid.
- `instr_ready`  in  1: decode accepts when `instr_valid` is also high.
- `redirect_valid`  in  1: one-cycle pulse; load `redirect_pc`.
- `redirect_pc`  in  16: branch/jump target.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Flag `drop_q` discards one stale response.
- IDLE: entered only from reset; moves to REQ after one cycle.
- REQ: `imem_req`=1. On `imem_gnt`, go to WAIT. `imem_addr` holds stable until the grant.
- WAIT: on `imem_rvalid` with `drop_q`=0, set `instr_o`<=`imem_rdata`, `instr_pc_o`<=`pc_q`, `pc_q`<=`pc_q`+1, and `instr_valid`<=1, then go to HOLD. With `drop_q`=1, discard the data, clear `drop_q`, and go to REQ.
- HOLD: on `instr_valid`&&`instr_ready`, `instr_valid`<=0 and go to REQ.
- Redirect has priority over all other events:
  - IDLE/REQ without a grant: `pc_q`<=`redirect_pc`; state is unchanged or goes to REQ.
  - REQ with a grant in the same cycle: go to WAIT with `drop_q`<=1 and `pc_q`<=`redirect_pc`.
  - WAIT without `rvalid`: `drop_q`<=1 and `pc_q`<=`redirect_pc`; stay in WAIT.
  - WAIT with `rvalid`: discard the data, `pc_q`<=`redirect_pc`, go to REQ.
  - HOLD: `instr_valid`<=0 even if `instr_ready`=1, `pc_q`<=`redirect_pc`, go to REQ.
- Arithmetic: the increment is modulo 2^16. 16'hFFFF+1 gives 16'h0000 and the carry-out is ignored.
- At most one outstanding request. `imem_rvalid` outside WAIT is ignored.

## Timing
- Reset values:
  - `pc_q`/`imem_addr` = `RESET_PC`
  - `imem_req` = 0, `instr_valid` = 0
  - `instr_o` = 0, `instr_pc_o` = 0
  - `drop_q` = 0, state = IDLE
- `imem_req` first rises in the second cycle after `rst_n` deasserts.
- With zero-wait memory (gnt while req is high, rvalid in the following cycle) and `instr_ready` held at 1, the rate is one instruction per 3 cycles: REQ, WAIT, HOLD.
- Reset asserted mid-operation clears everything immediately. A response arriving after reset is ignored because the state is IDLE.
- Outputs are registered. `imem_req` and `imem_addr` are decoded from the state and `pc_q` only, with no combinational path from any input.

## Structure
- Package `cpu_pkg`:
  - typedef `fetch_state_t` for the four states.
  - constant `PC_W`=16.
  - constant `INSTR_W`=16.
- Sub-module `pc_incr`: 16-bit adder with b=16'h0001 and cin=0. It is the only adder in the block. Its `cout` output is left unconnected.

## Test plan
- Reset with `RESET_PC`=16'h0010, zero-wait memory, `instr_ready`=1:
  - fetch addresses are 0x0010, 0x0011, 0x0012
  - `instr_pc_o` matches each address
  - `instr_valid` pulses every 3 cycles.
- Decode backpressure: `instr_ready`=0 for 5 cycles while in HOLD. `instr_o` stays stable, `imem_req` stays 0, and no address advances.
- Redirect to 0x0200 while in WAIT, with `rvalid` 2 cycles later. The stale word is never presented and the next fetch address is 0x0200.
- Redirect to 0x0040 in the same cycle as a grant for 0x0005. The 0x0005 response is dropped and the next `instr_pc_o` is 0x0040.
- Wrap-around: redirect to 0xFFFF. Successive `instr_pc_o` values are 0xFFFF then 0x0000.
- Assert `rst_n` in WAIT, then deliver `rvalid` after release. No `instr_valid`, and fetch restarts at `RESET_PC`.
